axis_multiflow_pkt_gen: RTL and testbench
=========================================

# axis_multiflow_pkt_gen

Parametrised AXI4-Stream packet generator feeding the CMAC TX AXIS port (or the ERNIC loopback path) in the exdes test designs. It supersedes the fixed single-stream generator. Data width, flow count and inter-packet gap are generic. It round-robins packets across enabled flows, supports burst and continuous modes, and produces a deterministic per-flow payload so RX-side checkers can validate every byte.

## Interface
- DATA_W, 512: AXIS data width in bits; multiple of 64.
- NUM_FLOWS, 4: number of flows, 1..16.
- MAX_PKT, 16000: maximum packet size in bytes.
- IFG_CYC, 0: idle cycles inserted after each packet, 0..255.

- aclk  in  1  sole clock (CMAC txusrclk2 domain).
- aresetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; launches a run from IDLE or DONE.
- continuous  in  1  1 = run until deasserted; 0 = send num_pkts.
- num_pkts  in  16  packets per run in burst mode.
- pkt_size  in  14  packet size in bytes; latched at start.
- flow_en  in  NUM_FLOWS  per-flow enable; latched at start.
- link_aligned  in  1  TX link ready (tied 1 in simplex mode).
- m_axis_tready  in  1  AXIS ready.
- m_axis_tvalid, m_axis_tlast, m_axis_tuser  out  1  AXIS valid/last/user (tuser always 0).
- m_axis_tdata  out  DATA_W  AXIS data.
- m_axis_tkeep  out  DATA_W/8  AXIS byte enables.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next start.
- pkt_cnt  out  32  packets completed in the current run.

## Operation
- States: IDLE, WAIT_ALIGN, SEND, GAP, DONE.
- IDLE/DONE + start:
  - If flow_en == 0, start is ignored.
  - If burst mode and num_pkts == 0, go directly to DONE.
  - Otherwise latch the configuration, clear pkt_cnt and done, set busy, and go to WAIT_ALIGN.
- Size latch: pkt_size is clamped to [64, MAX_PKT].
- WAIT_ALIGN -> SEND when link_aligned == 1.
- Beats per packet: B = ceil(size / (DATA_W/8)).
- tkeep: all ones on non-last beats. On the last beat, the low R bits are set, where R = size mod (DATA_W/8); if R == 0, all bits are set.
- Payload: byte k of a packet = (k + flow_id) mod 256.
- Flow selection:
  - Round-robin over set flow_en bits.
  - The first packet of a run uses the lowest enabled flow.
  - The pointer advances after each tlast handshake and wraps.
- Packet end: on tlast handshake, pkt_cnt increments.
  - Go to GAP if IFG_CYC > 0, else straight to the next packet.
  - Terminating condition: burst mode with pkt_cnt reaching num_pkts, or continuous == 0 in continuous mode. On termination go to DONE (done = 1, busy = 0).
- Continuous deassertion mid-packet: the current packet completes; no truncation.
- link_aligned drop:
  - In SEND: ignored until the packet boundary.
  - At a packet boundary: return to WAIT_ALIGN.
- start while busy: ignored.

## Timing
- Reset values: tvalid = 0, tlast = 0, tuser = 0, tdata = 0, tkeep = 0, busy = 0, done = 0, pkt_cnt = 0, state = IDLE.
- All outputs are registered.
- First tvalid appears 2 cycles after the start pulse when link_aligned is already 1 (start -> WAIT_ALIGN -> SEND).
- tvalid, tdata, tkeep and tlast are held stable while tready == 0. The generator never deasserts tvalid mid-packet.
- With IFG_CYC = 0 and tready constantly 1: one beat per cycle, back-to-back packets, no bubble.
- With IFG_CYC = N: exactly N cycles of tvalid = 0 between the tlast handshake and the next first beat.
- done and busy update in the cycle after the final tlast handshake.
- pkt_cnt saturates at 0xFFFFFFFF in continuous mode.

## Configuration
- PKTGEN_SEQNUM_EN defined:
  - First beat bytes [3:0] carry pkt_cnt (little-endian, value before increment).
  - Byte 4 carries flow_id.
  - All remaining bytes follow the payload rule.
- Not defined: pure payload pattern on every byte.

## Structure
- Package pktgen_pkg:
  - State enum.
  - BYTES_PER_BEAT(DATA_W) function.
  - MIN_PKT = 64.
  - Payload byte function.
- Sub-module pktgen_beat_calc: combinational/registered computation of B and the last-beat tkeep from the latched size; one instance.
- Flow arbiter and FSM are inline in the top.

## Test plan
- DATA_W = 512, pkt_size = 522, num_pkts = 3, one flow, tready = 1 -> 9 beats per packet, last tkeep = 0x3FF, pkt_cnt = 3, done = 1.
- pkt_size = 40 -> clamped to 64: 1 beat, tkeep all ones, tlast = 1.
- flow_en = 4'b1010, num_pkts = 4 -> flow order 1, 3, 1, 3; first payload byte 1, 3, 1, 3 (with PKTGEN_SEQNUM_EN undefined).
- Random tready backpressure (~50%) -> tdata/tkeep/tlast stable while stalled; byte-exact payload; 1000 packets counted.
- continuous = 1, deasserted in the middle of beat 5 of 9 -> packet finishes with tlast on beat 9, then DONE.
- IFG_CYC = 3 and PKTGEN_SEQNUM_EN defined -> exactly 3 idle cycles between packets; first-beat bytes [3:0] = 0, 1, 2.

Source files
------------

// File: rtl/pktgen_pkg.sv
// Shared types and helpers for the multi-flow AXI4-Stream packet generator.
package pktgen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_ALIGN,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } state_e;

  localparam int unsigned MIN_PKT = 64;

  function automatic int unsigned bytes_per_beat(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // Byte k of a packet on a given flow
  function automatic logic [7:0] payload_byte(input int unsigned k, input logic [7:0] flow);
    return 8'(k + 32'(flow));
  endfunction

endpackage

// File: rtl/axis_multiflow_pkt_gen_if.sv
// AXI4-Stream bus bundle between the packet generator and its sink.
interface axis_multiflow_pkt_gen_if #(
  parameter int unsigned DATA_W = 512
);
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tkeep;

  modport master (output tvalid, tlast, tuser, tdata, tkeep, input tready);
  modport slave  (input tvalid, tlast, tuser, tdata, tkeep, output tready);
endinterface

// File: rtl/pktgen_beat_calc.sv
// Registers the last-beat index and last-beat byte enables for a latched packet size.
module pktgen_beat_calc
  import pktgen_pkg::*;
#(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned SIZE_W = 14,
  parameter int unsigned BEAT_W = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [SIZE_W-1:0]     size_i,
  output logic [BEAT_W-1:0]     last_beat_o,
  output logic [DATA_W/8-1:0]   last_keep_o
);
  localparam int unsigned BPB    = bytes_per_beat(DATA_W);
  localparam int unsigned KEEP_W = DATA_W / 8;

  logic [31:0]        rem_c;
  logic [BEAT_W-1:0]  last_beat_d, last_beat_q;
  logic [KEEP_W-1:0]  last_keep_d, last_keep_q;

  always_comb begin
    rem_c       = 32'(size_i) % BPB;
    last_beat_d = BEAT_W'((32'(size_i) + BPB - 1) / BPB - 1);
    last_keep_d = (rem_c == 32'd0) ? '1 : (KEEP_W'(1) << rem_c) - KEEP_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_beat_q <= '0;
      last_keep_q <= '0;
    end else if (load_i) begin
      last_beat_q <= last_beat_d;
      last_keep_q <= last_keep_d;
    end
  end

  assign last_beat_o = last_beat_q;
  assign last_keep_o = last_keep_q;

endmodule

// File: rtl/axis_multiflow_pkt_gen.sv
// Round-robin multi-flow AXI4-Stream packet generator with burst/continuous runs.
// Optional feature: define PKTGEN_SEQNUM_EN to put pkt_cnt and flow_id in the first beat.
module axis_multiflow_pkt_gen
  import pktgen_pkg::*;
#(
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned NUM_FLOWS = 4,
  parameter int unsigned MAX_PKT   = 16000,
  parameter int unsigned IFG_CYC   = 0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic                  continuous,
  input  logic [15:0]           num_pkts,
  input  logic [13:0]           pkt_size,
  input  logic [NUM_FLOWS-1:0]  flow_en,
  input  logic                  link_aligned,
  axis_multiflow_pkt_gen_if.master m_axis,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           pkt_cnt
);
  localparam int unsigned BPB    = bytes_per_beat(DATA_W);
  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned FLOW_W = (NUM_FLOWS > 1) ? $clog2(NUM_FLOWS) : 1;
  localparam int unsigned SIZE_W = 14;
  localparam int unsigned BEAT_W = 14;
  localparam int unsigned GAP_W  = 8;

  state_e                state_q, state_d;
  logic [NUM_FLOWS-1:0]  flow_en_q, flow_en_d;
  logic [15:0]           num_pkts_q, num_pkts_d;
  logic                  cont_q, cont_d;
  logic [FLOW_W-1:0]     flow_q, flow_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [31:0]           pkt_cnt_q, pkt_cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic [KEEP_W-1:0]     tkeep_q, tkeep_d;
  logic [DATA_W-1:0]     tdata_q, tdata_d;

  logic                  latch_c;
  logic                  load_c;
  logic                  term_c;
  logic [SIZE_W-1:0]     size_clamp_c;
  logic [BEAT_W-1:0]     last_beat;
  logic [KEEP_W-1:0]     last_keep;

  // Next enabled flow after cur, wrapping; with cur = NUM_FLOWS-1 this is the lowest enabled flow
  function automatic logic [FLOW_W-1:0] next_flow(input logic [NUM_FLOWS-1:0] en,
                                                  input logic [FLOW_W-1:0]    cur);
    logic [FLOW_W-1:0]    nf;
    logic [NUM_FLOWS-1:0] sh;
    logic                 found;
    int unsigned          idx;
    nf    = cur;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_FLOWS; i++) begin
      idx = (32'(cur) + i) % NUM_FLOWS;
      sh  = en >> idx;
      if (!found && sh[0]) begin
        nf    = FLOW_W'(idx);
        found = 1'b1;
      end
    end
    return nf;
  endfunction

  function automatic logic [DATA_W-1:0] beat_data(input logic [FLOW_W-1:0] flow,
                                                  input logic [BEAT_W-1:0] beat);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int unsigned j = 0; j < BPB; j++) begin
      d = {payload_byte(32'(beat) * BPB + j, 8'(flow)), d[DATA_W-1:8]};
    end
    return d;
  endfunction

  always_comb begin
    if (32'(pkt_size) < MIN_PKT)      size_clamp_c = SIZE_W'(MIN_PKT);
    else if (32'(pkt_size) > MAX_PKT) size_clamp_c = SIZE_W'(MAX_PKT);
    else                              size_clamp_c = pkt_size;
  end

  pktgen_beat_calc #(
    .DATA_W (DATA_W),
    .SIZE_W (SIZE_W),
    .BEAT_W (BEAT_W)
  ) u_beat_calc (
    .clk         (aclk),
    .rst_n       (aresetn),
    .load_i      (latch_c),
    .size_i      (size_clamp_c),
    .last_beat_o (last_beat),
    .last_keep_o (last_keep)
  );

  // Next-state and output-register logic
  always_comb begin
    state_d    = state_q;
    flow_en_d  = flow_en_q;
    num_pkts_d = num_pkts_q;
    cont_d     = cont_q;
    flow_d     = flow_q;
    beat_d     = beat_q;
    gap_d      = gap_q;
    pkt_cnt_d  = pkt_cnt_q;
    busy_d     = busy_q;
    done_d     = done_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    tkeep_d    = tkeep_q;
    tdata_d    = tdata_q;
    latch_c    = 1'b0;
    load_c     = 1'b0;
    term_c     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start && (flow_en != '0)) begin
          pkt_cnt_d = '0;
          if (!continuous && (num_pkts == '0)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            latch_c    = 1'b1;
            flow_en_d  = flow_en;
            num_pkts_d = num_pkts;
            cont_d     = continuous;
            flow_d     = next_flow(flow_en, FLOW_W'(NUM_FLOWS - 1));
            done_d     = 1'b0;
            busy_d     = 1'b1;
            state_d    = ST_WAIT_ALIGN;
          end
        end
      end

      ST_WAIT_ALIGN: begin
        if (link_aligned) begin
          state_d = ST_SEND;
          beat_d  = '0;
          load_c  = 1'b1;
        end
      end

      ST_SEND: begin
        if (tvalid_q && m_axis.tready) begin
          if (!tlast_q) begin
            beat_d = beat_q + BEAT_W'(1);
            load_c = 1'b1;
          end else begin
            pkt_cnt_d = (pkt_cnt_q == '1) ? pkt_cnt_q : pkt_cnt_q + 32'd1;
            flow_d    = next_flow(flow_en_q, flow_q);
            tvalid_d  = 1'b0;
            tlast_d   = 1'b0;
            term_c    = cont_q ? !continuous : (pkt_cnt_d == 32'(num_pkts_q));
            if (term_c) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else if (IFG_CYC > 0) begin
              state_d = ST_GAP;
              gap_d   = GAP_W'(IFG_CYC - 1);
            end else if (link_aligned) begin
              beat_d = '0;
              load_c = 1'b1;
            end else begin
              state_d = ST_WAIT_ALIGN;
            end
          end
        end
      end

      ST_GAP: begin
        if (gap_q == '0) begin
          if (link_aligned) begin
            state_d = ST_SEND;
            beat_d  = '0;
            load_c  = 1'b1;
          end else begin
            state_d = ST_WAIT_ALIGN;
          end
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (load_c) begin
      tvalid_d = 1'b1;
      tlast_d  = (beat_d == last_beat);
      tkeep_d  = tlast_d ? last_keep : '1;
      tdata_d  = beat_data(flow_d, beat_d);
`ifdef PKTGEN_SEQNUM_EN
      if (beat_d == '0) begin
        tdata_d[31:0]  = pkt_cnt_d;
        tdata_d[39:32] = 8'(flow_d);
      end
`endif
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      flow_en_q  <= '0;
      num_pkts_q <= '0;
      cont_q     <= 1'b0;
      flow_q     <= '0;
      beat_q     <= '0;
      gap_q      <= '0;
      pkt_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tkeep_q    <= '0;
      tdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      flow_en_q  <= flow_en_d;
      num_pkts_q <= num_pkts_d;
      cont_q     <= cont_d;
      flow_q     <= flow_d;
      beat_q     <= beat_d;
      gap_q      <= gap_d;
      pkt_cnt_q  <= pkt_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tkeep_q    <= tkeep_d;
      tdata_q    <= tdata_d;
    end
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tuser  = 1'b0;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tkeep  = tkeep_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pkt_cnt       = pkt_cnt_q;

endmodule

// File: tb/tb_axis_multiflow_pkt_gen.sv
// Directed self-checking bench: dut0 with no inter-packet gap, dut1 with a 3-cycle gap.
module tb_axis_multiflow_pkt_gen;
  logic        clk;
  logic        rst_n;
  logic        start, start1, continuous, link_aligned, tready;
  logic [15:0] num_pkts;
  logic [13:0] pkt_size;
  logic [3:0]  flow_en;
  logic        busy0, done0, busy1, done1;
  logic [31:0] pkt_cnt0, pkt_cnt1;
  int          n_checks;
  int          n_fail;
  bit          rand_rdy;

  axis_multiflow_pkt_gen_if #(.DATA_W(512)) ax0 ();
  axis_multiflow_pkt_gen_if #(.DATA_W(512)) ax1 ();
  assign ax0.tready = tready;
  assign ax1.tready = tready;

  axis_multiflow_pkt_gen #(.DATA_W(512), .NUM_FLOWS(4), .MAX_PKT(16000), .IFG_CYC(0)) dut0 (
    .aclk(clk), .aresetn(rst_n), .start(start), .continuous(continuous),
    .num_pkts(num_pkts), .pkt_size(pkt_size), .flow_en(flow_en),
    .link_aligned(link_aligned), .m_axis(ax0), .busy(busy0), .done(done0), .pkt_cnt(pkt_cnt0)
  );

  axis_multiflow_pkt_gen #(.DATA_W(512), .NUM_FLOWS(4), .MAX_PKT(16000), .IFG_CYC(3)) dut1 (
    .aclk(clk), .aresetn(rst_n), .start(start1), .continuous(continuous),
    .num_pkts(num_pkts), .pkt_size(pkt_size), .flow_en(flow_en),
    .link_aligned(link_aligned), .m_axis(ax1), .busy(busy1), .done(done1), .pkt_cnt(pkt_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Byte k of beat b on flow f is (64*b + k + f) mod 256
  function automatic logic [511:0] exp_data(input int flow, input int beat);
    logic [511:0] d;
    d = '0;
    for (int j = 0; j < 64; j++) d = {8'(beat * 64 + j + flow), d[511:8]};
    return d;
  endfunction

  function automatic logic [511:0] keep_mask(input logic [63:0] k);
    logic [511:0] m;
    logic [63:0]  kk;
    m  = '0;
    kk = k;
    for (int i = 0; i < 64; i++) begin
      m  = {{8{kk[0]}}, m[511:8]};
      kk = kk >> 1;
    end
    return m;
  endfunction

  function automatic logic [63:0] last_keep(input int size);
    int r;
    r = size % 64;
    return (r == 0) ? '1 : (64'(1) << r) - 64'(1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) tready = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Receive one packet on dut0, checking every accepted beat and stall stability
  task automatic recv_pkt(input int flow, input int size, input int seq, input int drop_at);
    int            nb, beat, cyc;
    bit            stalled;
    logic [511:0]  pd, ed, mk;
    logic [63:0]   pk, ek;
    logic          pl, el;
    nb = (size + 63) / 64;
    beat = 0; cyc = 0; stalled = 1'b0;
    pd = '0; pk = '0; pl = 1'b0;
    while (ax0.tvalid !== 1'b1 && cyc < 200) begin tick(); cyc++; end
    n_checks++;
    if (ax0.tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL pkt%0d_first_beat: tvalid=%b, required 1", seq, ax0.tvalid);
      return;
    end
    while (beat < nb && cyc < 5000) begin
      if (beat == drop_at) continuous = 1'b0;
      n_checks++;
      if (ax0.tvalid !== 1'b1) begin
        n_fail++;
        $display("FAIL pkt%0d_tvalid_hold beat %0d: tvalid=%b, required 1", seq, beat, ax0.tvalid);
        return;
      end
      if (stalled) begin
        n_checks++;
        if ({ax0.tdata, ax0.tkeep, ax0.tlast} !== {pd, pk, pl}) begin
          n_fail++;
          $display("FAIL pkt%0d_stall_stable beat %0d: keep=%h last=%b, required keep=%h last=%b",
                   seq, beat, ax0.tkeep, ax0.tlast, pk, pl);
        end
      end
      if (tready) begin
        el = (beat == nb - 1);
        ek = el ? last_keep(size) : '1;
        ed = exp_data(flow, beat);
`ifdef PKTGEN_SEQNUM_EN
        if (beat == 0) begin ed[31:0] = 32'(seq); ed[39:32] = 8'(flow); end
`endif
        mk = keep_mask(ek);
        n_checks++;
        if (ax0.tkeep !== ek) begin
          n_fail++;
          $display("FAIL pkt%0d_tkeep beat %0d: got %h, required %h", seq, beat, ax0.tkeep, ek);
        end
        n_checks++;
        if (ax0.tlast !== el) begin
          n_fail++;
          $display("FAIL pkt%0d_tlast beat %0d: got %b, required %b", seq, beat, ax0.tlast, el);
        end
        n_checks++;
        if ((ax0.tdata & mk) !== (ed & mk)) begin
          n_fail++;
          $display("FAIL pkt%0d_tdata beat %0d: got %h, required %h", seq, beat, ax0.tdata & mk, ed & mk);
        end
        beat++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        pd = ax0.tdata; pk = ax0.tkeep; pl = ax0.tlast;
      end
      tick();
      cyc++;
    end
    n_checks++;
    if (beat < nb) begin
      n_fail++;
      $display("FAIL pkt%0d_timeout: %0d beats received, required %0d", seq, beat, nb);
    end
  endtask

  task automatic test_reset();
    n_checks++; if (ax0.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b, required 0", ax0.tvalid); end
    n_checks++; if (ax0.tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b, required 0", ax0.tlast); end
    n_checks++; if (ax0.tuser !== 1'b0) begin n_fail++; $display("FAIL reset_tuser: got %b, required 0", ax0.tuser); end
    n_checks++; if (ax0.tdata !== '0) begin n_fail++; $display("FAIL reset_tdata: got %h, required 0", ax0.tdata); end
    n_checks++; if (ax0.tkeep !== '0) begin n_fail++; $display("FAIL reset_tkeep: got %h, required 0", ax0.tkeep); end
    n_checks++; if ({busy0, done0} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_done: got %b, required 00", {busy0, done0}); end
    n_checks++; if (pkt_cnt0 !== 32'd0) begin n_fail++; $display("FAIL reset_pkt_cnt: got %0d, required 0", pkt_cnt0); end
  endtask

  task automatic test_burst_522();
    pkt_size = 14'd522; num_pkts = 16'd3; flow_en = 4'b0001; continuous = 1'b0;
    pulse_start();
    n_checks++; if ({ax0.tvalid, busy0} !== 2'b01) begin n_fail++; $display("FAIL latency_wait_align: tvalid,busy=%b, required 01", {ax0.tvalid, busy0}); end
    tick();
    n_checks++; if (ax0.tvalid !== 1'b1) begin n_fail++; $display("FAIL latency_first_beat: tvalid=%b, required 1", ax0.tvalid); end
    recv_pkt(0, 522, 0, -1);
    n_checks++; if (ax0.tvalid !== 1'b1) begin n_fail++; $display("FAIL back_to_back_1: tvalid=%b, required 1", ax0.tvalid); end
    start = 1'b1; pkt_size = 14'd64;
    recv_pkt(0, 522, 1, -1);
    start = 1'b0; pkt_size = 14'd522;
    n_checks++; if (ax0.tvalid !== 1'b1) begin n_fail++; $display("FAIL back_to_back_2: tvalid=%b, required 1", ax0.tvalid); end
    recv_pkt(0, 522, 2, -1);
    n_checks++; if ({done0, busy0, ax0.tvalid} !== 3'b100) begin n_fail++; $display("FAIL burst_done: done,busy,tvalid=%b, required 100", {done0, busy0, ax0.tvalid}); end
    n_checks++; if (pkt_cnt0 !== 32'd3) begin n_fail++; $display("FAIL burst_pkt_cnt: got %0d, required 3", pkt_cnt0); end
  endtask

  task automatic test_clamp();
    pkt_size = 14'd40; num_pkts = 16'd1; flow_en = 4'b0100;
    pulse_start();
    recv_pkt(2, 64, 0, -1);
    n_checks++; if ({done0, pkt_cnt0} !== {1'b1, 32'd1}) begin n_fail++; $display("FAIL clamp_done: done=%b cnt=%0d, required 1 and 1", done0, pkt_cnt0); end
  endtask

  task automatic test_round_robin();
    pkt_size = 14'd64; num_pkts = 16'd4; flow_en = 4'b1010;
    pulse_start();
    recv_pkt(1, 64, 0, -1);
    recv_pkt(3, 64, 1, -1);
    recv_pkt(1, 64, 2, -1);
    recv_pkt(3, 64, 3, -1);
    n_checks++; if ({done0, pkt_cnt0} !== {1'b1, 32'd4}) begin n_fail++; $display("FAIL rr_done: done=%b cnt=%0d, required 1 and 4", done0, pkt_cnt0); end
  endtask

  task automatic test_backpressure();
    pkt_size = 14'd100; num_pkts = 16'd1000; flow_en = 4'b1111;
    rand_rdy = 1'b1;
    pulse_start();
    for (int i = 0; i < 1000; i++) recv_pkt(i % 4, 100, i, -1);
    rand_rdy = 1'b0;
    tready = 1'b1;
    n_checks++; if ({done0, busy0} !== 2'b10) begin n_fail++; $display("FAIL bp_done: done,busy=%b, required 10", {done0, busy0}); end
    n_checks++; if (pkt_cnt0 !== 32'd1000) begin n_fail++; $display("FAIL bp_pkt_cnt: got %0d, required 1000", pkt_cnt0); end
  endtask

  task automatic test_ignored_start();
    flow_en = 4'b0000; num_pkts = 16'd5;
    pulse_start();
    tick();
    n_checks++; if ({done0, busy0, pkt_cnt0} !== {2'b10, 32'd1000}) begin n_fail++; $display("FAIL no_flow_start: done=%b busy=%b cnt=%0d, required 1 0 1000", done0, busy0, pkt_cnt0); end
    flow_en = 4'b0001; num_pkts = 16'd0;
    pulse_start();
    tick(); tick();
    n_checks++; if ({done0, busy0, ax0.tvalid, pkt_cnt0} !== {3'b100, 32'd0}) begin n_fail++; $display("FAIL zero_pkts: done=%b busy=%b tvalid=%b cnt=%0d, required 1 0 0 0", done0, busy0, ax0.tvalid, pkt_cnt0); end
  endtask

  task automatic test_link_align();
    pkt_size = 14'd200; num_pkts = 16'd2; flow_en = 4'b0001; link_aligned = 1'b0;
    pulse_start();
    repeat (4) tick();
    n_checks++; if ({ax0.tvalid, busy0, done0} !== 3'b010) begin n_fail++; $display("FAIL link_wait: tvalid,busy,done=%b, required 010", {ax0.tvalid, busy0, done0}); end
    link_aligned = 1'b1;
    tick();
    n_checks++; if (ax0.tvalid !== 1'b1) begin n_fail++; $display("FAIL link_release: tvalid=%b, required 1", ax0.tvalid); end
    link_aligned = 1'b0;
    recv_pkt(0, 200, 0, -1);
    tick(); tick();
    n_checks++; if ({ax0.tvalid, busy0, pkt_cnt0} !== {2'b01, 32'd1}) begin n_fail++; $display("FAIL link_boundary: tvalid=%b busy=%b cnt=%0d, required 0 1 1", ax0.tvalid, busy0, pkt_cnt0); end
    link_aligned = 1'b1;
    recv_pkt(0, 200, 1, -1);
    n_checks++; if ({done0, pkt_cnt0} !== {1'b1, 32'd2}) begin n_fail++; $display("FAIL link_done: done=%b cnt=%0d, required 1 and 2", done0, pkt_cnt0); end
  endtask

  task automatic test_continuous();
    pkt_size = 14'd522; num_pkts = 16'd1; flow_en = 4'b0001; continuous = 1'b1;
    pulse_start();
    recv_pkt(0, 522, 0, -1);
    recv_pkt(0, 522, 1, 4);
    n_checks++; if ({done0, busy0, ax0.tvalid} !== 3'b100) begin n_fail++; $display("FAIL cont_stop: done,busy,tvalid=%b, required 100", {done0, busy0, ax0.tvalid}); end
    n_checks++; if (pkt_cnt0 !== 32'd2) begin n_fail++; $display("FAIL cont_pkt_cnt: got %0d, required 2", pkt_cnt0); end
    continuous = 1'b0;
  endtask

  task automatic test_ifg();
    int            idle, pkts, cyc;
    logic [511:0]  ed;
    pkt_size = 14'd64; num_pkts = 16'd3; flow_en = 4'b0001; continuous = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    idle = 0; pkts = 0; cyc = 0;
    while (pkts < 3 && cyc < 100) begin
      if (ax1.tvalid === 1'b1) begin
        ed = exp_data(0, 0);
`ifdef PKTGEN_SEQNUM_EN
        ed[31:0] = 32'(pkts); ed[39:32] = 8'h00;
`endif
        n_checks++;
        if ({ax1.tdata, ax1.tlast} !== {ed, 1'b1}) begin
          n_fail++;
          $display("FAIL ifg_beat%0d: tdata=%h tlast=%b, required %h and 1", pkts, ax1.tdata, ax1.tlast, ed);
        end
        if (pkts > 0) begin
          n_checks++;
          if (idle != 3) begin n_fail++; $display("FAIL ifg_gap%0d: %0d idle cycles, required 3", pkts, idle); end
        end
        pkts++;
        idle = 0;
      end else begin
        idle++;
      end
      tick();
      cyc++;
    end
    n_checks++; if (pkts != 3) begin n_fail++; $display("FAIL ifg_count: %0d packets seen, required 3", pkts); end
    n_checks++; if ({done1, busy1, pkt_cnt1} !== {2'b10, 32'd3}) begin n_fail++; $display("FAIL ifg_done: done=%b busy=%b cnt=%0d, required 1 0 3", done1, busy1, pkt_cnt1); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; rand_rdy = 1'b0;
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0; continuous = 1'b0;
    num_pkts = '0; pkt_size = '0; flow_en = '0; link_aligned = 1'b1; tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_burst_522();
    test_clamp();
    test_round_robin();
    test_backpressure();
    test_ignored_start();
    test_link_align();
    test_continuous();
    test_ifg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
